// File: rtl/pipe_seg_buf.sv
// Elastic pipeline segment register with valid/ready handshake, flush and stall counter.
// Define PIPE_SEG_SKID_EN for the two-entry skid variant with registered in_ready.
module pipe_seg_buf #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_cnt_clr
);

  logic [WIDTH-1:0] main_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

`ifdef PIPE_SEG_SKID_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;

  // in_ready_q tracks (next state != FULL) so upstream never sees out_ready combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            main_q  <= in_data;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            main_q <= in_data;
          end else if (in_valid) begin
            skid_q     <= in_data;
            state_q    <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (out_ready) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            main_q     <= skid_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
`else
  logic valid_q;
  logic accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      main_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign occupancy = {1'b0, valid_q};
`endif

  assign out_data = main_q;

  // Saturating back-pressure counter; clear wins, flush is ignored
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_seg_buf.md
# pipe_seg_buf

Parametrised elastic pipeline segment register, the next generation of the fixed-field inter-stage registers between EX, EC and later stages. It carries an opaque WIDTH-bit payload under a valid/ready handshake in place of a global stall, supports a synchronous flush in place of refresh, and holds up to two entries so upstream ready is registered. It also provides an occupancy output and a saturating back-pressure counter for performance debug.

## Interface

Parameters:
- WIDTH, 64, payload width in bits; legal range is 1..1024.
- CNT_W, 16, width of the back-pressure counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all held entries (pipeline refresh).
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  segment can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_data  out  WIDTH  head entry payload; driven directly from a register.
- out_ready  in  1  downstream accepts the head this cycle.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.

One clock; reset is asynchronous and active-high.

## Operation

- Accept is defined as in_valid && in_ready. Pop is defined as out_valid && out_ready.
- Storage is a main register (head, drives out_data) and a skid register.
- State is EMPTY (occupancy 0), ONE (occupancy 1) or FULL (occupancy 2). out_valid = (state != EMPTY).
- EMPTY:
  - On accept, main <= in_data and the state goes to ONE.
- ONE:
  - Accept and pop together: main <= in_data; state stays ONE.
  - Accept without pop: skid <= in_data; state goes to FULL.
  - Pop without accept: state goes to EMPTY.
- FULL:
  - in_ready = 0.
  - On pop, main <= skid and the state goes to ONE.
- in_ready is registered: it is 1 unless the state is FULL. It never depends on out_ready in the same cycle.
- Ordering is strictly FIFO. No payload is duplicated or lost except by flush or reset.
- flush:
  - Has priority over accept and pop in the same cycle.
  - Next state is EMPTY; main and skid are cleared to 0.
  - A payload presented in the flush cycle is dropped, even if in_ready = 1.
- stall_cnt:
  - Increments in every cycle where out_valid && !out_ready, and saturates at all-ones.
  - stall_cnt_clr has priority over increment.
  - flush does not affect stall_cnt.
- Reset values: state EMPTY, out_valid 0, out_data 0, skid 0, in_ready 1, occupancy 0, stall_cnt 0.
- Reset takes effect asynchronously mid-transfer. Any held entries are lost.

## Timing

- Latency is 1 cycle: a payload accepted at edge N is visible on out_data and out_valid after edge N.
- Throughput is 1 payload per cycle in steady state while out_ready = 1.
- Back-pressure: in_ready falls 1 cycle after the second entry is captured. It rises 1 cycle after a pop from FULL.
- out_valid and out_data must remain stable while out_valid && !out_ready, except when flush or reset is asserted.
- The first accept is possible in the cycle after reset deasserts.

## Configuration

Macro: PIPE_SEG_SKID_EN.
- Defined: the two-entry skid operation above; in_ready is registered.
- Undefined: the skid register and the FULL state are removed.
  - in_ready = !out_valid || out_ready, which is combinational.
  - occupancy is at most 1.
  - Latency, flush behaviour, reset values and stall_cnt behaviour are unchanged.

## Test plan

All scenarios use WIDTH=8 and CNT_W=4 unless stated otherwise.
- Streaming: out_ready=1 and in_data 0x01..0x10 on consecutive cycles -> out_data 0x01..0x10 one cycle later, with no gaps.
- Back-pressure (SKID_EN): push 0xA1, 0xA2, 0xA3 with out_ready=0 -> occupancy 2, in_ready 0, 0xA3 not accepted. Then raise out_ready -> 0xA1 and 0xA2 pop in order; in_ready rises the cycle after the first pop.
- Flush priority: occupancy 2 and flush=1 with in_valid=1, in_data=0x55 -> next cycle occupancy 0, out_valid 0, out_data 0x00, and 0x55 never emerges.
- Counter saturation: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 0xF and stays there. Assert stall_cnt_clr together with a stall cycle -> 0x0.
- Async reset mid-transfer: assert reset between edges with occupancy 2 -> outputs go to their reset values immediately, without waiting for a clock edge. After deassert, in_ready = 1 and an accept of 0x3C appears on out_data one cycle later.
- No-skid build (macro undefined): in the cycle out_valid=1, out_ready=1 -> in_ready=1 in the same cycle, and back-to-back transfers run at 1 per cycle.
